// File: rtl/wishbone_dma_pkg.sv
// Shared definitions for the wishbone_dma copy engine: register offsets,
// CTRL bit positions, FSM encoding and the initiator request payload.
package wishbone_dma_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  // Register offsets as decoded from wb_adr[3:2]
  localparam logic [1:0] DMA_SRC  = 2'd0;
  localparam logic [1:0] DMA_DST  = 2'd1;
  localparam logic [1:0] DMA_LEN  = 2'd2;
  localparam logic [1:0] DMA_CTRL = 2'd3;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_BUSY   = 1;
  localparam int unsigned CTRL_DONE   = 2;
  localparam int unsigned CTRL_ERR    = 3;
  localparam int unsigned CTRL_IRQ_EN = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_GAP   = 2'd3
  } dma_state_e;

  typedef struct packed {
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] mosi;
  } bus_req_t;

  // Replace only the bytes of old_val selected by sel
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [SEL_W-1:0]  sel);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(SEL_W); i++) begin
      if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wishbone_dma_engine.sv
// Copy engine: walks LEN words from SRC to DST as read/write beat pairs,
// with a one-cycle cyc gap after each word so the crossbar can re-arbitrate.
module wishbone_dma_engine
  import wishbone_dma_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    src,
  input  logic [ADDR_W-1:0]    dst,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [DATA_W-1:0]    bus_miso,
  input  logic                 bus_ack,
  input  logic                 bus_err,
  output bus_req_t             req,
  output logic                 busy,
  output logic                 done_c,
  output logic                 err_c
);

  dma_state_e           state;
  logic [ADDR_W-1:0]    cur_src;
  logic [ADDR_W-1:0]    cur_dst;
  logic [LEN_WIDTH-1:0] count;

  // Completion and fault are flagged in the cycle the FSM leaves for IDLE
  assign done_c = (state == ST_GAP) && (count == '0);
  assign err_c  = ((state == ST_READ) || (state == ST_WRITE)) && bus_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      req     <= '0;
      cur_src <= '0;
      cur_dst <= '0;
      count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (len != '0)) begin
            state    <= ST_READ;
            busy     <= 1'b1;
            cur_src  <= src;
            cur_dst  <= dst;
            count    <= len;
            req.cyc  <= 1'b1;
            req.stb  <= 1'b1;
            req.we   <= 1'b0;
            req.adr  <= src;
          end
        end
        ST_READ: begin
          if (bus_err) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            req.cyc <= 1'b0;
            req.stb <= 1'b0;
            req.we  <= 1'b0;
          end else if (bus_ack) begin
            state    <= ST_WRITE;
            req.we   <= 1'b1;
            req.adr  <= cur_dst;
            req.mosi <= bus_miso;
          end
        end
        ST_WRITE: begin
          if (bus_err) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            req.cyc <= 1'b0;
            req.stb <= 1'b0;
            req.we  <= 1'b0;
          end else if (bus_ack) begin
            state   <= ST_GAP;
            cur_src <= cur_src + ADDR_W'(4);
            cur_dst <= cur_dst + ADDR_W'(4);
            count   <= count - LEN_WIDTH'(1);
            req.cyc <= 1'b0;
            req.stb <= 1'b0;
            req.we  <= 1'b0;
          end
        end
        ST_GAP: begin
          if (count != '0) begin
            state   <= ST_READ;
            req.cyc <= 1'b1;
            req.stb <= 1'b1;
            req.adr <= cur_src;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          req   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/wishbone_dma.sv
// Single-channel memory-to-memory DMA: CPU-facing register file and
// Wishbone responder, irq generation, and the initiator copy engine.
module wishbone_dma
  import wishbone_dma_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16,
  parameter logic [2:0]  TAG       = 3'b000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [2:0]        wb_tag,
  input  logic [SEL_W-1:0]  wb_sel,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [DATA_W-1:0] wb_mosi,
  output logic [DATA_W-1:0] wb_miso,
  output logic              wb_ack,
  output logic              wb_err,
  output logic              bus_cyc,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [2:0]        bus_tag,
  output logic [SEL_W-1:0]  bus_sel,
  output logic [ADDR_W-1:0] bus_adr,
  output logic [DATA_W-1:0] bus_mosi,
  input  logic [DATA_W-1:0] bus_miso,
  input  logic              bus_ack,
  input  logic              bus_err,
  output logic              irq
);

  logic [ADDR_W-1:0]    src_q, src_n, dst_q, dst_n;
  logic [LEN_WIDTH-1:0] len_q, len_n;
  logic                 done_q, done_n, err_q, err_n, irq_en_q, irq_en_n;
  logic [DATA_W-1:0]    rd_data_c, len_merge_c;
  logic                 wb_req_c, wb_wr_c, ctrl_wr_c, start_c;
  logic                 busy, eng_done_c, eng_err_c;
  bus_req_t             req;
  logic                 unused_ok;

  assign wb_err    = 1'b0;
  assign bus_tag   = TAG;
  assign bus_sel   = '1;
  assign bus_cyc   = req.cyc;
  assign bus_stb   = req.stb;
  assign bus_we    = req.we;
  assign bus_adr   = req.adr;
  assign bus_mosi  = req.mosi;
  assign unused_ok = &{1'b0, wb_tag, wb_adr[31:4], wb_adr[1:0], len_merge_c};

  // A strobe held through its ack cycle is taken as the next request
  assign wb_req_c  = wb_cyc & wb_stb & ~wb_ack;
  assign wb_wr_c   = wb_req_c & wb_we;
  assign ctrl_wr_c = wb_wr_c && (wb_adr[3:2] == DMA_CTRL) && wb_sel[0];

  // Next-state of the register file; engine events override CPU clears
  always_comb begin
    src_n       = src_q;
    dst_n       = dst_q;
    len_n       = len_q;
    done_n      = done_q;
    err_n       = err_q;
    irq_en_n    = irq_en_q;
    start_c     = 1'b0;
    len_merge_c = byte_merge(DATA_W'(len_q), wb_mosi, wb_sel);
    if (wb_wr_c && !busy) begin
      case (wb_adr[3:2])
        DMA_SRC: src_n = byte_merge(src_q, wb_mosi, wb_sel) & ~DATA_W'(3);
        DMA_DST: dst_n = byte_merge(dst_q, wb_mosi, wb_sel) & ~DATA_W'(3);
        DMA_LEN: len_n = len_merge_c[LEN_WIDTH-1:0];
        default: ;
      endcase
    end
    if (ctrl_wr_c) begin
      irq_en_n = wb_mosi[CTRL_IRQ_EN];
      if (wb_mosi[CTRL_DONE]) done_n = 1'b0;
      if (wb_mosi[CTRL_ERR])  err_n  = 1'b0;
      start_c = wb_mosi[CTRL_START] & ~busy;
    end
    if (start_c) begin
      err_n  = 1'b0;
      done_n = (len_q == '0);
    end
    if (eng_done_c) done_n = 1'b1;
    if (eng_err_c)  err_n  = 1'b1;
  end

  always_comb begin
    rd_data_c = '0;
    case (wb_adr[3:2])
      DMA_SRC: rd_data_c = src_q;
      DMA_DST: rd_data_c = dst_q;
      DMA_LEN: rd_data_c = DATA_W'(len_q);
      default: begin
        rd_data_c[CTRL_BUSY]   = busy;
        rd_data_c[CTRL_DONE]   = done_q;
        rd_data_c[CTRL_ERR]    = err_q;
        rd_data_c[CTRL_IRQ_EN] = irq_en_q;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
      wb_ack   <= 1'b0;
      wb_miso  <= '0;
    end else begin
      src_q    <= src_n;
      dst_q    <= dst_n;
      len_q    <= len_n;
      done_q   <= done_n;
      err_q    <= err_n;
      irq_en_q <= irq_en_n;
      irq      <= irq_en_n & (done_n | err_n);
      wb_ack   <= wb_req_c;
      if (wb_req_c) wb_miso <= rd_data_c;
    end
  end

  wishbone_dma_engine #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_engine (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .start   (start_c),
    .src     (src_q),
    .dst     (dst_q),
    .len     (len_q),
    .bus_miso(bus_miso),
    .bus_ack (bus_ack),
    .bus_err (bus_err),
    .req     (req),
    .busy    (busy),
    .done_c  (eng_done_c),
    .err_c   (eng_err_c)
  );

endmodule

// File: tb/tb_wishbone_dma.sv
// Bench for wishbone_dma: register table, directed copy/error/reset sequences
// and randomized copies checked against a word-list reference of the copy.
module tb_wishbone_dma;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        wb_cyc, wb_stb, wb_we;
  logic [2:0]  wb_tag;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_mosi, wb_miso;
  logic        wb_ack, wb_err;
  logic        bus_cyc, bus_stb, bus_we;
  logic [2:0]  bus_tag;
  logic [3:0]  bus_sel;
  logic [31:0] bus_adr, bus_mosi, bus_miso;
  logic        bus_ack, bus_err;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  wishbone_dma #(.LEN_WIDTH(16), .TAG(3'b101)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_tag(wb_tag),
    .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_mosi(wb_mosi), .wb_miso(wb_miso),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_tag(bus_tag),
    .bus_sel(bus_sel), .bus_adr(bus_adr), .bus_mosi(bus_mosi), .bus_miso(bus_miso),
    .bus_ack(bus_ack), .bus_err(bus_err), .irq(irq)
  );

  // Memory slave: source data comes from mem[], writes are logged, not stored
  logic [31:0] mem [4096];
  logic [31:0] rd_adr_q[$];
  logic [31:0] wr_adr_q[$];
  logic [31:0] wr_dat_q[$];
  int max_delay = 0;
  int err_at = 0;
  int n_wr_beats = 0;
  int wcnt = -1;

  always @(posedge sys_clk) begin : slave
    int d;
    bus_ack <= 1'b0;
    bus_err <= 1'b0;
    if (!bus_stb) begin
      wcnt <= -1;
    end else if (bus_cyc && !bus_ack && !bus_err) begin
      d = (wcnt < 0) ? int'($urandom_range(max_delay, 0)) : wcnt;
      if (d > 0) begin
        wcnt <= d - 1;
      end else begin
        wcnt <= -1;
        if (bus_we) begin
          n_wr_beats <= n_wr_beats + 1;
          if (n_wr_beats + 1 == err_at) begin
            bus_err <= 1'b1;
          end else begin
            bus_ack <= 1'b1;
            wr_adr_q.push_back(bus_adr);
            wr_dat_q.push_back(bus_mosi);
          end
        end else begin
          bus_miso <= mem[bus_adr[13:2]];
          bus_ack  <= 1'b1;
          rd_adr_q.push_back(bus_adr);
        end
      end
    end
  end

  // Initiator protocol watcher: beat stability, cyc drop after err, cyc activity
  logic        mon_en = 1'b0;
  int          stab_viol = 0, errdrop_viol = 0, cyc_rise = 0, cyc_high = 0;
  logic        p_stb = 1'b0, p_resp = 1'b0, p_we = 1'b0, p_err = 1'b0, p_cyc = 1'b0;
  logic [31:0] p_adr = '0, p_mosi = '0;

  always @(negedge sys_clk) begin
    if (mon_en && p_stb && !p_resp &&
        !(bus_stb && bus_adr == p_adr && bus_we == p_we && (!p_we || bus_mosi == p_mosi)))
      stab_viol <= stab_viol + 1;
    if (mon_en && p_err && bus_cyc) errdrop_viol <= errdrop_viol + 1;
    if (bus_cyc && !p_cyc) cyc_rise <= cyc_rise + 1;
    if (bus_cyc) cyc_high <= cyc_high + 1;
    p_stb  <= bus_stb;
    p_resp <= bus_ack | bus_err;
    p_we   <= bus_we;
    p_err  <= bus_err;
    p_cyc  <= bus_cyc;
    p_adr  <= bus_adr;
    p_mosi <= bus_mosi;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    int n;
    @(negedge sys_clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_mosi = dat; wb_sel = sel;
    n = 0;
    rd = '0;
    do begin
      @(posedge sys_clk); #1;
      n++;
    end while (!wb_ack && n < 8);
    if (!wb_ack) begin
      n_vec++;
      n_err++;
      $display("FAIL wb_timeout: no ack at adr %h", adr);
    end else begin
      rd = wb_miso;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wreg(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic rreg(input logic [31:0] a, output logic [31:0] d);
    wb_xfer(1'b0, a, 32'h0, 4'hF, d);
  endtask

  // Program and run one copy; reference is the list of words src+4i -> dst+4i
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input logic ien, input int mdly, input bit timed, input bit poke);
    int rb, wb0, cr0, ch0, sv0, n;
    logic [31:0] rd, ea, eb;
    rb = rd_adr_q.size(); wb0 = wr_adr_q.size();
    cr0 = cyc_rise; ch0 = cyc_high; sv0 = stab_viol;
    max_delay = mdly;
    wreg(32'h0, src);
    wreg(32'h4, dst);
    wreg(32'h8, 32'(len));
    wreg(32'hC, (32'(ien) << 5) | 32'h1);
    if (poke) wreg(32'h4, 32'h0000_5000);
    if (ien) begin
      n = 0;
      while (!irq && n < 1000) begin
        @(posedge sys_clk); #1;
        n++;
      end
      check("irq_after_copy", 32'(irq), 32'h1);
      if (timed) check("done_cycle", n, 5 * len);
    end else begin
      rd = 32'h2;
      for (int k = 0; k < 400; k++) begin
        rreg(32'hC, rd);
        if (!rd[1]) break;
      end
      check("busy_clear", 32'(rd[1]), 32'h0);
      check("irq_masked", 32'(irq), 32'h0);
    end
    rreg(32'hC, rd);
    check("copy_ctrl", rd, 32'h4 | (32'(ien) << 5));
    check("read_beats", rd_adr_q.size() - rb, len);
    check("write_beats", wr_adr_q.size() - wb0, len);
    for (int i = 0; i < len; i++) begin
      ea = src + 32'(4 * i);
      eb = dst + 32'(4 * i);
      if (rd_adr_q.size() > rb + i) check("read_adr", rd_adr_q[rb + i], ea);
      if (wr_adr_q.size() > wb0 + i) begin
        check("write_adr", wr_adr_q[wb0 + i], eb);
        check("write_data", wr_dat_q[wb0 + i], mem[ea[13:2]]);
      end
    end
    check("cyc_bursts", cyc_rise - cr0, len);
    check("beat_stable", stab_viol - sv0, 0);
    if (timed) check("cyc_high_cycles", cyc_high - ch0, 4 * len);
    if (poke) begin
      rreg(32'h4, rd);
      check("dst_busy_protect", rd, dst & ~32'h3);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] exp;
    string       name;
  } reg_vec_t;

  reg_vec_t tbl[10];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int n, cr0, wb0, ev0;

    tbl[0] = '{32'h0, 32'h1234_5677, 4'hF, 32'h1234_5674, "src_full"};
    tbl[1] = '{32'h0, 32'hFFFF_FFAB, 4'h1, 32'h1234_56A8, "src_byte0"};
    tbl[2] = '{32'h0, 32'hCDEF_0000, 4'hC, 32'hCDEF_56A8, "src_upper"};
    tbl[3] = '{32'h4, 32'h0000_2003, 4'hF, 32'h0000_2000, "dst_full"};
    tbl[4] = '{32'h4, 32'h0000_AA00, 4'h2, 32'h0000_AA00, "dst_byte1"};
    tbl[5] = '{32'h8, 32'hFFFF_FFFF, 4'hF, 32'h0000_FFFF, "len_mask"};
    tbl[6] = '{32'h8, 32'h0000_0000, 4'h2, 32'h0000_00FF, "len_byte1"};
    tbl[7] = '{32'hC, 32'h0000_002C, 4'hF, 32'h0000_0020, "ctrl_irqen"};
    tbl[8] = '{32'hC, 32'h0000_0000, 4'hE, 32'h0000_0020, "ctrl_nosel0"};
    tbl[9] = '{32'hC, 32'h0000_0000, 4'hF, 32'h0000_0000, "ctrl_clear"};

    foreach (mem[i]) mem[i] = $urandom;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_tag = 3'b111;
    wb_sel = 4'h0; wb_adr = '0; wb_mosi = '0;
    sys_rst_n = 1'b0;

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_bus_cyc", 32'(bus_cyc), 32'h0);
    check("rst_bus_stb", 32'(bus_stb), 32'h0);
    check("rst_bus_we", 32'(bus_we), 32'h0);
    check("rst_bus_adr", bus_adr, 32'h0);
    check("rst_bus_mosi", bus_mosi, 32'h0);
    check("rst_wb_ack", 32'(wb_ack), 32'h0);
    check("rst_wb_miso", wb_miso, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    mon_en = 1'b1;
    check("bus_tag", 32'(bus_tag), 32'h5);
    check("bus_sel", 32'(bus_sel), 32'hF);
    for (int a = 0; a < 4; a++) begin
      rreg(32'(4 * a), rd);
      check("rst_reg", rd, 32'h0);
    end

    // Register access table: write then read back
    for (int i = 0; i < 10; i++) begin
      wb_xfer(1'b1, tbl[i].adr, tbl[i].wdat, tbl[i].sel, rd);
      rreg(tbl[i].adr, rd);
      check(tbl[i].name, rd, tbl[i].exp);
    end

    // Strobe held high: ack must alternate, one per request
    @(negedge sys_clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0; wb_sel = 4'hF;
    n = 0;
    repeat (6) begin
      @(posedge sys_clk); #1;
      if (wb_ack) n++;
      check("wb_err_low", 32'(wb_err), 32'h0);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    check("ack_pulses", n, 3);

    // Directed copy with one-cycle slave: 5 cycles per word
    run_copy(32'h1000, 32'h2000, 4, 1'b1, 0, 1'b1, 1'b0);

    // Zero length
    wreg(32'hC, 32'h0000_000C);
    check("irq_cleared", 32'(irq), 32'h0);
    cr0 = cyc_rise;
    wreg(32'h8, 32'h0);
    wreg(32'hC, 32'h0000_0021);
    check("zero_irq", 32'(irq), 32'h1);
    rreg(32'hC, rd);
    check("zero_ctrl", rd, 32'h24);
    repeat (3) @(posedge sys_clk);
    #1;
    check("zero_no_cyc", cyc_rise - cr0, 0);

    // Error on the second write beat
    err_at = n_wr_beats + 2;
    max_delay = 0;
    wb0 = wr_adr_q.size();
    ev0 = errdrop_viol;
    wreg(32'h0, 32'h1000);
    wreg(32'h4, 32'h2000);
    wreg(32'h8, 32'h4);
    wreg(32'hC, 32'h21);
    n = 0;
    while (!irq && n < 200) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check("err_irq", 32'(irq), 32'h1);
    rreg(32'hC, rd);
    check("err_ctrl", rd, 32'h28);
    check("err_words_written", wr_adr_q.size() - wb0, 1);
    check("err_cyc_drop", errdrop_viol - ev0, 0);
    rreg(32'h0, rd);
    check("err_src_kept", rd, 32'h1000);
    rreg(32'h8, rd);
    check("err_len_kept", rd, 32'h4);
    wreg(32'hC, 32'h28);
    check("err_irq_clear", 32'(irq), 32'h0);
    rreg(32'hC, rd);
    check("err_ctrl_clear", rd, 32'h20);
    err_at = 0;

    // Wait states
    run_copy(32'h1100, 32'h2100, 6, 1'b1, 3, 1'b0, 1'b0);

    // Address wrap plus DST write while busy
    run_copy(32'hFFFF_FFFC, 32'h2000, 2, 1'b1, 0, 1'b0, 1'b1);

    // Randomized copies
    for (int t = 0; t < 6; t++) begin
      logic [31:0] s, d;
      int l, md;
      logic ie;
      s  = 32'h1000 + 32'(4 * $urandom_range(0, 255));
      d  = 32'h3000 + 32'(4 * $urandom_range(0, 255));
      l  = int'($urandom_range(1, 12));
      md = int'($urandom_range(0, 3));
      ie = 1'($urandom_range(0, 1));
      run_copy(s, d, l, ie, md, (md == 0) && ie, 1'b0);
    end

    // Reset asserted during a write beat
    max_delay = 0;
    wreg(32'h0, 32'h1000);
    wreg(32'h4, 32'h2000);
    wreg(32'h8, 32'h4);
    wreg(32'hC, 32'h21);
    n = 0;
    while (!(bus_stb && bus_we) && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check("reach_write_beat", 32'(bus_stb && bus_we), 32'h1);
    mon_en = 1'b0;
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    check("rst_mid_cyc", 32'(bus_cyc), 32'h0);
    check("rst_mid_stb", 32'(bus_stb), 32'h0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    check("rst_mid_irq", 32'(irq), 32'h0);
    for (int a = 0; a < 4; a++) begin
      rreg(32'(4 * a), rd);
      check("rst_mid_reg", rd, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wishbone_dma.md
# wishbone_dma

Single-channel memory-to-memory copy engine for the SoC Wishbone fabric. Exposes a Wishbone responder port for CPU configuration and a Wishbone initiator port that attaches as a second master on `wishbone_crossbar`. Once started, it copies LEN 32-bit words from SRC to DST with one read beat and one write beat per word. It raises `irq` on completion.

## Interface
Parameters:
- `LEN_WIDTH`, 16: width of the word-count register; maximum transfer is 2^LEN_WIDTH−1 words.
- `TAG`, 3'b000: constant value driven on `bus_tag`.

Ports:
- `sys_clk` in 1: single clock for the whole block.
- `sys_rst_n` in 1: reset, synchronous, active-low.
- `wb_cyc`, `wb_stb`, `wb_we` in 1 each: configuration responder strobes.
- `wb_tag` in 3: ignored.
- `wb_sel` in 4: byte enables; a write updates only the selected bytes.
- `wb_adr` in 32: only bits [3:2] are decoded.
- `wb_mosi` in 32: write data.
- `wb_miso` out 32: read data.
- `wb_ack`, `wb_err` out 1 each: responder acknowledge and error.
- `bus_cyc`, `bus_stb`, `bus_we` out 1 each: initiator strobes.
- `bus_tag` out 3: always `TAG`.
- `bus_sel` out 4: always 4'hF.
- `bus_adr` out 32: word-aligned beat address.
- `bus_mosi` out 32: write data.
- `bus_miso` in 32: read data.
- `bus_ack`, `bus_err` in 1 each: initiator acknowledge and error.
- `irq` out 1: level interrupt.

## Operation
Register map (offset = `wb_adr[3:2]`×4):
- 0x0 SRC: source address, R/W. Bits [1:0] read as 0.
- 0x4 DST: destination address, R/W. Bits [1:0] read as 0.
- 0x8 LEN: word count, R/W. Bits above `LEN_WIDTH` read as 0.
- 0xC CTRL:
  - bit0 START: write 1 to start; reads 0.
  - bit1 BUSY: read-only.
  - bit2 DONE: write 1 to clear.
  - bit3 ERR: write 1 to clear.
  - bit5 IRQ_EN: R/W.

Register rules:
- Writes to SRC, DST and LEN while BUSY are ignored; they are still acknowledged.
- START while BUSY is ignored.
- `irq` = IRQ_EN & (DONE | ERR).

FSM states: IDLE, READ, WRITE, GAP.
- IDLE → READ on START when LEN≠0. Working copies of SRC, DST and LEN are loaded at this point, and DONE and ERR are cleared.
- START when LEN=0: DONE sets on the next cycle, BUSY never asserts, and no bus traffic occurs.
- READ: drives cyc=stb=1, we=0, adr=src. On ack, captures `bus_miso` into the data buffer and moves to WRITE.
- WRITE: drives cyc=stb=1, we=1, adr=dst, mosi=buffer. On ack, src+=4, dst+=4, count−=1, then moves to GAP.
- GAP: cyc=0 for exactly one cycle so the crossbar can re-arbitrate. Moves to READ if count≠0. Otherwise moves to IDLE and sets DONE.
- `bus_err` in READ or WRITE: set ERR, drop cyc next cycle, go to IDLE. The working copies are discarded and the SRC/DST/LEN registers are unchanged.
- ack and err in the same cycle: err wins.
- Address arithmetic is 32-bit modulo. Incrementing past 0xFFFFFFFC wraps to 0x00000000 with no fault.
- BUSY = (state ≠ IDLE).

## Timing
- Responder: `wb_ack` pulses one cycle after `wb_cyc & wb_stb`, for one cycle, and never twice for the same request. A strobe held across an ack is a new request. `wb_err` is always 0. `wb_miso` is valid in the ack cycle.
- Initiator outputs are registered. stb stays asserted and adr/we/mosi stay stable until the cycle in which ack or err is sampled. stb drops, or the beat changes, on the following edge.
- With a slave that acks one cycle after stb, one word takes 5 cycles: 2 read, 2 write, 1 gap.
- DONE/`irq` assert on the edge that leaves GAP for IDLE.
- Reset values:
  - All `bus_*` strobes 0; `bus_adr` = 0; `bus_mosi` = 0.
  - `wb_ack` 0; `wb_miso` 0; `irq` 0.
  - All registers 0; state IDLE.
- Reset asserted mid-transfer drops `bus_cyc` on the next edge with no completion.

## Structure
- Shared header `dma_defs.vh`:
  - Register offsets (`DMA_SRC`, `DMA_DST`, `DMA_LEN`, `DMA_CTRL`).
  - CTRL bit indices.
  - FSM state encodings.
- Sub-module `dma_engine` holds the FSM, working counters and data buffer, and is natural to split out.
- `wishbone_dma` holds the register file, the responder port and the irq logic.

## Test plan
- Copy path: SRC=0x1000, DST=0x2000, LEN=4, START, memory model with 1-cycle ack → words copied in order, 8 beats, 4 one-cycle cyc gaps, DONE at cycle 20 after start, `irq` high with IRQ_EN=1.
- Zero length: LEN=0, START → DONE set next cycle, BUSY never 1, `bus_cyc` never asserted.
- Error: slave returns `bus_err` on the second write → ERR=1, cyc drops next cycle, only 1 word written, SRC register still 0x1000; writing 1 to bit3 clears ERR and `irq`.
- Wait states: slave inserts 3-cycle random ack delays → stb, adr and mosi stable until ack; data correct; `bus_we` low on every read beat.
- Busy protection and wrap: writing DST during a transfer has no effect; SRC=0xFFFFFFFC with LEN=2 → second read address is 0x00000000.
- Reset mid-transfer: `sys_rst_n`=0 during a WRITE beat → cyc=0 next edge, all registers read 0 afterwards.
